mix_a_uart: RTL

// Downstream consumer of the MIX core's 31-bit A-register output `a`.

---
 rtl/mix_a_uart.sv | 103 ++++++++++
 1 files changed

// File: rtl/mix_a_uart.sv
`timescale 1ns/1ps
// mix_a_uart: prints each new MIX A-register value as "+dddddddddd\r\n" over an 8N1 UART.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   a        - MIX word: [30] sign (1 = minus), [29:0] five 6-bit bytes
//   tx       - UART serial output, idle high, LSB first
//   busy     - high while a line is being shifted out
//   lost_cnt - saturating count of changes on a seen while busy
module mix_a_uart #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [30:0] a,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  lost_cnt
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LOAD = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [30:0] a_q, a_qd, sent_q, sent_d, word_q, word_d;
  logic [3:0]  char_q, char_d;
  logic [2:0]  bit_q, bit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        tx_q, tx_d, busy_q, busy_d;
  logic [7:0]  lost_q, lost_d;
  logic [2:0]  dig;
  logic [7:0]  chr;
  logic        bit_end;
  // digit k of the word sits at bits [32-3k -: 3], i.e. a right shift of 30-3k
  assign dig = 3'(word_q[29:0] >> (6'd30 - 6'(char_q) * 6'd3));
  assign chr = char_q == 4'd0  ? (word_q[30] ? 8'h2D : 8'h2B) :
               char_q == 4'd11 ? 8'h0D :
               char_q == 4'd12 ? 8'h0A : 8'h30 + {5'b0, dig};
  assign bit_end = timer_q == '0;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sent_d  = sent_q;
    char_d  = char_q;
    bit_d   = bit_q;
    // every bit end enters a new bit (or IDLE), so reloading there is always right
    timer_d = (state_q == IDLE || bit_end) ? T_LOAD : timer_q - 1'b1;
    lost_d  = (busy_q && a_q != a_qd && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
    case (state_q)
      IDLE: if (a_q != sent_q) begin
        word_d  = a_q;
        sent_d  = a_q;
        char_d  = 4'd0;
        state_d = START;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (bit_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        state_d = char_q == 4'd12 ? IDLE : START;
        char_d  = char_q == 4'd12 ? char_q : char_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // word and char_idx never change on entry to DATA, so chr already reflects the next char
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? chr[bit_d] : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      a_qd    <= '0;
      sent_q  <= '0;
      word_q  <= '0;
      char_q  <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a;
      a_qd    <= a_q;
      sent_q  <= sent_d;
      word_q  <= word_d;
      char_q  <= char_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      lost_q  <= lost_d;
    end
  end
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign lost_cnt = lost_q;
endmodule
